seq_mult_collector: RTL
=======================

Name: seq_mult_collector

Overview:
Downstream stage of the bit-serial multiplier. Captures the P-bit product digits that the multiplier emits LSB-first and assembles them into a full 2*MAX_WIDTH-bit product word, zero-extended or sign-extended. Presents each product on a valid/ready output. The multiplier has no backpressure, so overrun and length mismatches are flagged with sticky error bits rather than stalled.

Parameters:
P, 2, digit width in bits; must match the multiplier's P.
MAX_WIDTH, 16, maximum operand width in bits; product word is 2*MAX_WIDTH bits.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  new multiplication begins; aligned with the multiplier's start.
bit_size  in  $clog2(MAX_WIDTH/P)+1  operand width in P-bit digits, legal range 1..MAX_WIDTH/P; sampled on start.
is_signed  in  1  sign-extend the product; sampled on start.
in_digit  in  P  product digit from the multiplier output register.
in_valid  in  1  in_digit is a new digit this cycle.
in_last  in  1  qualifies in_valid; this is the final digit of the product.
out_data  out  2*MAX_WIDTH  assembled, extended product.
out_valid  out  1  out_data holds an undelivered product.
out_ready  in  1  consumer accepts out_data when out_valid=1.
err_overrun  out  1  sticky; a product completed while the previous one was still held.
err_len  out  1  sticky; the digit count disagreed with 2*bit_size.
err_clr  in  1  clears both sticky error bits.

Behaviour:
- Reset: all outputs 0, digit count 0, assembly register 0, state IDLE.
- State machine, states IDLE, COLLECT, DRAIN:
  - IDLE: on start → COLLECT; latch bit_size and is_signed; clear count and assembly register.
  - COLLECT, on each in_valid: write in_digit to assembly bits [count*P +: P]; count++.
  - DRAIN: entered on a length error. Ignore in_valid until the next start.
- Expected digit count E = 2*bit_size.
- Completion: in_valid && in_last with count+1 == E.
  - Next cycle: out_data = assembly extended from bit 2*bit_size*P-1 (sign-extended if is_signed, else zero-extended); out_valid=1.
  - State → IDLE. Latency is exactly one cycle from the last digit to out_valid.
- Length error, either of:
  - in_last with count+1 != E;
  - in_valid without in_last when count+1 == E.
  - Effect: set err_len, discard the product, state → DRAIN.
- Output handshake: the product transfers on the cycle with out_valid && out_ready; out_valid → 0 the next cycle unless a new product loads.
  - out_data is stable while out_valid=1 and out_ready=0.
- Completion while out_valid=1:
  - out_ready=1 that cycle: the new product replaces the old one and out_valid stays 1 (back-to-back, no bubble).
  - out_ready=0: set err_overrun, drop the new product, keep the held one.
- start in any state, including mid-COLLECT and DRAIN: aborts the current assembly without an error; behaves as start from IDLE. It does not affect a held output.
- start and in_valid in the same cycle: start wins and the digit is ignored. A digit can only be accepted from the cycle after start.
- in_valid in IDLE: ignored, no error.
- err_clr has priority over a same-cycle error set. Error bits do not block operation.
- Illegal bit_size (0 or above MAX_WIDTH/P): behaviour undefined; an assertion in the bench checks it.
- Reset mid-operation: immediate return to reset values, including dropping any held product.

Test Plan:
1. P=2, MAX_WIDTH=16, bit_size=2, unsigned; digits 10,01,11,00 (last on 4th) → one cycle later out_valid=1, out_data=0x00000036.
2. Same, is_signed=1, digits 10,01,11,11 → out_data=0xFFFFFFF6; out_ready held low 5 cycles → data stable, then transfers on the first ready cycle.
3. bit_size=8, unsigned, 16 digits of 11 → out_data=0xFFFFFFFF; signed → 0xFFFFFFFF; digits 01 then 15×00 → out_data=0x00000001.
4. bit_size=2: in_last on the 3rd digit → err_len=1, no out_valid; further digits ignored; next start with 4 good digits → correct product, err_len stays 1 until err_clr.
5. Product A held with out_ready=0; product B completes → err_overrun=1 and A retained. Repeat with out_ready=1 on B's completion cycle → B loads with no bubble and no error.
6. rst asserted mid-COLLECT after 2 digits → all outputs 0 asynchronously; start mid-COLLECT → earlier digits discarded and the fresh 4-digit product is correct.

Source files
------------

// File: rtl/seq_mult_collector_if.sv
// Digit-in / product-out bundle between the bit-serial multiplier, the collector and its consumer.
// Handshake: out_data moves on a cycle with out_valid && out_ready; in_valid has no backpressure.
interface seq_mult_collector_if #(
    parameter int P         = 2,
    parameter int MAX_WIDTH = 16
);
    localparam int BSW = $clog2(MAX_WIDTH / P) + 1;

    logic                   start;
    logic [BSW-1:0]         bit_size;
    logic                   is_signed;
    logic [P-1:0]           in_digit;
    logic                   in_valid;
    logic                   in_last;
    logic [2*MAX_WIDTH-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   err_overrun;
    logic                   err_len;
    logic                   err_clr;

    modport master (
        output start, bit_size, is_signed, in_digit, in_valid, in_last, out_ready, err_clr,
        input  out_data, out_valid, err_overrun, err_len
    );

    modport slave (
        input  start, bit_size, is_signed, in_digit, in_valid, in_last, out_ready, err_clr,
        output out_data, out_valid, err_overrun, err_len
    );
endinterface

// File: rtl/seq_mult_collector.sv
// Assembles LSB-first product digits into a 2*MAX_WIDTH-bit word, extends it and holds it
// on a valid/ready output; overrun and length faults raise sticky error flags instead of stalling.
module seq_mult_collector #(
    parameter int P         = 2,
    parameter int MAX_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_mult_collector_if.slave   bus,
    output logic [1:0]            dbg_state
);
    localparam int W   = 2 * MAX_WIDTH;
    localparam int ND  = W / P;
    localparam int NB  = MAX_WIDTH / P;
    localparam int BSW = $clog2(NB) + 1;
    localparam int CW  = $clog2(ND) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [W-1:0]   asm_q;
    logic [BSW-1:0] bs_q;
    logic           sg_q;

    logic [CW-1:0]  count_inc;
    logic [CW-1:0]  exp_cnt;
    logic [W-1:0]   asm_wr;
    logic [W-1:0]   ext_word;
    logic           sign_bit;
    logic           do_write;
    logic           do_complete;
    logic           do_len_err;
    logic           ovr_set;

    assign dbg_state = state;

    always_comb begin
        count_inc = count + CW'(1);
        exp_cnt   = CW'({bs_q, 1'b0});

        // Assembly word as it looks with this cycle's digit already merged in.
        asm_wr = asm_q;
        for (int i = 0; i < ND; i++) begin
            if (count == CW'(i)) asm_wr[i*P +: P] = bus.in_digit;
        end

        sign_bit = 1'b0;
        for (int i = 1; i <= NB; i++) begin
            if (bs_q == BSW'(i)) sign_bit = asm_wr[2*i*P-1];
        end

        ext_word = '0;
        for (int b = 0; b < W; b++) begin
            ext_word[b] = (b < int'(bs_q) * 2 * P) ? asm_wr[b] : (sg_q & sign_bit);
        end

        do_write    = (state == COLLECT) && bus.in_valid && !bus.start;
        do_complete = do_write && bus.in_last && (count_inc == exp_cnt);
        do_len_err  = do_write && (bus.in_last ? (count_inc != exp_cnt) : (count_inc == exp_cnt));
        ovr_set     = do_complete && bus.out_valid && !bus.out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            asm_q           <= '0;
            bs_q            <= '0;
            sg_q            <= 1'b0;
            bus.out_data    <= '0;
            bus.out_valid   <= 1'b0;
            bus.err_overrun <= 1'b0;
            bus.err_len     <= 1'b0;
        end else begin
            // start overrides everything on the input side, including a same-cycle digit.
            if (bus.start) begin
                state <= COLLECT;
                bs_q  <= bus.bit_size;
                sg_q  <= bus.is_signed;
                count <= '0;
                asm_q <= '0;
            end else if (state == COLLECT) begin
                if (do_complete) begin
                    state <= IDLE;
                end else if (do_len_err) begin
                    state <= DRAIN;
                end else if (do_write) begin
                    asm_q <= asm_wr;
                    count <= count_inc;
                end
            end

            if (do_complete && (!bus.out_valid || bus.out_ready)) begin
                bus.out_data  <= ext_word;
                bus.out_valid <= 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            bus.err_overrun <= bus.err_clr ? 1'b0 : (bus.err_overrun | ovr_set);
            bus.err_len     <= bus.err_clr ? 1'b0 : (bus.err_len | do_len_err);
        end
    end
endmodule
